// File: rtl/sc_game_pkg.sv
// Shared constants, grade codes and payload types for the note-scoring path.
package sc_game_pkg;

  localparam int unsigned NUM_NOTES  = 37;
  localparam int unsigned TIME_W     = 18;
  localparam int unsigned ERR_W      = 8;
  localparam int unsigned SCORE_W    = 24;
  localparam int unsigned COMBO_W    = 12;
  localparam int unsigned NOTE_IDX_W = 6;
  localparam int unsigned MULT_W     = 3;
  localparam int unsigned DROP_W     = 8;
  localparam int unsigned POINTS_W   = 7;

  localparam int unsigned WIN_PERFECT = 8;
  localparam int unsigned WIN_GOOD    = 20;
  localparam int unsigned WIN_OK      = 40;

  localparam logic [1:0] GRADE_MISS    = 2'd0;
  localparam logic [1:0] GRADE_OK      = 2'd1;
  localparam logic [1:0] GRADE_GOOD    = 2'd2;
  localparam logic [1:0] GRADE_PERFECT = 2'd3;

  localparam int unsigned PTS_MISS    = 0;
  localparam int unsigned PTS_OK      = 20;
  localparam int unsigned PTS_GOOD    = 50;
  localparam int unsigned PTS_PERFECT = 100;

  localparam int unsigned MAX_MULT       = 4;
  localparam int unsigned COMBO_PER_MULT = 10;

  // Registered arbitration winner handed from select to grade stage.
  typedef struct packed {
    logic [NOTE_IDX_W-1:0] note;
    logic [ERR_W-1:0]      err;
  } sel_t;

  // Timing error to grade code.
  function automatic logic [1:0] grade_of(input logic [ERR_W-1:0] err);
    if (err <= ERR_W'(WIN_PERFECT))   return GRADE_PERFECT;
    else if (err <= ERR_W'(WIN_GOOD)) return GRADE_GOOD;
    else if (err <= ERR_W'(WIN_OK))   return GRADE_OK;
    else                              return GRADE_MISS;
  endfunction

  // Base points for a grade, before the multiplier.
  function automatic logic [POINTS_W-1:0] points_of(input logic [1:0] g);
    case (g)
      GRADE_PERFECT: return POINTS_W'(PTS_PERFECT);
      GRADE_GOOD:    return POINTS_W'(PTS_GOOD);
      GRADE_OK:      return POINTS_W'(PTS_OK);
      default:       return POINTS_W'(PTS_MISS);
    endcase
  endfunction

endpackage

// File: rtl/sc_rr_arbiter.sv
// Combinational N-way round-robin arbiter.
// Grants the lowest requesting index at or above ptr, wrapping past N-1 to 0.
//   req     : request vector
//   ptr     : search start index (must be < N)
//   gnt_c   : one-hot grant
//   idx_c   : granted index
//   valid_c : any request granted
module sc_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             valid_c
);

  // Scan N candidates starting at ptr; first hit wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      cand = sum[IDX_W-1:0];
      if (!valid_c && req[cand]) begin
        valid_c     = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/sc_note_scorer.sv
// Note scorer: captures per-lane timing errors from the matcher array,
// serialises hits through a round-robin arbiter and grades/accumulates them.
//   clk, reset    : clock, synchronous active-high reset
//   song_time     : current song time
//   match_trigger : one-cycle per-lane match pulse
//   match_time    : per-lane scheduled note time, lane i at [TIME_W*i +: TIME_W]
//   grade_valid   : one-cycle pulse per graded hit, with grade / grade_note
//   score, combo, max_combo, multiplier : running HUD state
//   drop_count    : hits lost to an already-pending lane (saturating)
module sc_note_scorer
  import sc_game_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TIME_W-1:0]             song_time,
  input  logic [NUM_NOTES-1:0]          match_trigger,
  input  logic [NUM_NOTES*TIME_W-1:0]   match_time,
  output logic                          grade_valid,
  output logic [1:0]                    grade,
  output logic [NOTE_IDX_W-1:0]         grade_note,
  output logic [SCORE_W-1:0]            score,
  output logic [COMBO_W-1:0]            combo,
  output logic [COMBO_W-1:0]            max_combo,
  output logic [MULT_W-1:0]             multiplier,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int unsigned CNT_W = $clog2(NUM_NOTES + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [NUM_NOTES-1:0]  pending;
  logic [ERR_W-1:0]      err_q [NUM_NOTES];
  logic [NOTE_IDX_W-1:0] ptr;
  sel_t                  sel_q;
  logic                  sel_valid;

  logic [NUM_NOTES-1:0]  arb_gnt_c;
  logic [NOTE_IDX_W-1:0] arb_idx_c;
  logic                  arb_valid_c;

  logic [ERR_W-1:0]      err_new_c [NUM_NOTES];
  logic [NUM_NOTES-1:0]  drop_vec_c;
  logic [CNT_W-1:0]      drop_cnt_c;
  logic [DROP_W:0]       drop_sum_c;

  sc_rr_arbiter #(
    .N     (NUM_NOTES),
    .IDX_W (NOTE_IDX_W)
  ) u_arb (
    .req     (pending),
    .ptr     (ptr),
    .gnt_c   (arb_gnt_c),
    .idx_c   (arb_idx_c),
    .valid_c (arb_valid_c)
  );

  // Per-lane saturated absolute timing error.
  always_comb begin
    logic [TIME_W-1:0] mt;
    logic [TIME_W:0]   diff;
    mt   = '0;
    diff = '0;
    for (int unsigned i = 0; i < NUM_NOTES; i++) begin
      mt = match_time[TIME_W*i +: TIME_W];
      if (song_time >= mt) diff = {1'b0, song_time} - {1'b0, mt};
      else                 diff = {1'b0, mt} - {1'b0, song_time};
      if (diff > (TIME_W+1)'(ERR_MAX)) err_new_c[i] = ERR_MAX;
      else                             err_new_c[i] = ERR_W'(diff);
    end
  end

  // A lane being granted this cycle frees its slot, so its retrigger is not a drop.
  always_comb begin
    drop_vec_c = match_trigger & pending & ~arb_gnt_c;
    drop_cnt_c = '0;
    for (int unsigned i = 0; i < NUM_NOTES; i++)
      drop_cnt_c = drop_cnt_c + CNT_W'(drop_vec_c[i]);
    drop_sum_c = {1'b0, drop_count} + (DROP_W+1)'(drop_cnt_c);
  end

  // Capture stage: pending bits, errors, arbiter pointer, drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      ptr        <= '0;
      drop_count <= '0;
      for (int unsigned i = 0; i < NUM_NOTES; i++) err_q[i] <= '0;
    end else begin
      pending <= (pending & ~arb_gnt_c) | match_trigger;
      for (int unsigned i = 0; i < NUM_NOTES; i++)
        if (match_trigger[i] && !drop_vec_c[i]) err_q[i] <= err_new_c[i];
      if (arb_valid_c)
        ptr <= (arb_idx_c == NOTE_IDX_W'(NUM_NOTES - 1)) ? '0
                                                         : arb_idx_c + NOTE_IDX_W'(1);
      drop_count <= drop_sum_c[DROP_W] ? '1 : drop_sum_c[DROP_W-1:0];
    end
  end

  // Select stage: register the winner with its pre-update error.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_valid <= 1'b0;
      sel_q     <= '0;
    end else begin
      sel_valid <= arb_valid_c;
      if (arb_valid_c) begin
        sel_q.note <= arb_idx_c;
        sel_q.err  <= err_q[arb_idx_c];
      end
    end
  end

  logic [1:0]          grade_c;
  logic [SCORE_W:0]    score_sum_c;
  logic [SCORE_W-1:0]  score_next_c;
  logic [COMBO_W-1:0]  combo_next_c;
  logic [COMBO_W-1:0]  max_next_c;
  logic [COMBO_W-1:0]  tiers_c;
  logic [MULT_W-1:0]   mult_next_c;

  // Grade stage arithmetic; points use the multiplier from before this hit.
  always_comb begin
    grade_c      = grade_of(sel_q.err);
    score_sum_c  = {1'b0, score}
                 + (SCORE_W+1)'(points_of(grade_c)) * (SCORE_W+1)'(multiplier);
    score_next_c = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
    if (grade_c == GRADE_MISS)  combo_next_c = '0;
    else if (combo == '1)       combo_next_c = combo;
    else                        combo_next_c = combo + COMBO_W'(1);
    max_next_c = (combo_next_c > max_combo) ? combo_next_c : max_combo;
    tiers_c    = combo_next_c / COMBO_W'(COMBO_PER_MULT);
    if (tiers_c >= COMBO_W'(MAX_MULT - 1)) mult_next_c = MULT_W'(MAX_MULT);
    else                                   mult_next_c = MULT_W'(tiers_c) + MULT_W'(1);
  end

  // Grade stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grade_valid <= 1'b0;
      grade       <= GRADE_MISS;
      grade_note  <= '0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
      multiplier  <= MULT_W'(1);
    end else begin
      grade_valid <= sel_valid;
      if (sel_valid) begin
        grade      <= grade_c;
        grade_note <= sel_q.note;
        score      <= score_next_c;
        combo      <= combo_next_c;
        max_combo  <= max_next_c;
        multiplier <= mult_next_c;
      end
    end
  end

endmodule

// File: tb/tb_sc_note_scorer.sv
// Self-checking bench for sc_note_scorer: scoreboard of expected grades
// pushed at stimulus time and popped when grade_valid pulses.
module tb_sc_note_scorer;

  localparam int NN = 37;
  localparam int TW = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [TW-1:0]     song_time = '0;
  logic [NN-1:0]     match_trigger = '0;
  logic [NN*TW-1:0]  match_time = '0;
  logic              grade_valid;
  logic [1:0]        grade;
  logic [5:0]        grade_note;
  logic [23:0]       score;
  logic [11:0]       combo;
  logic [11:0]       max_combo;
  logic [2:0]        multiplier;
  logic [7:0]        drop_count;

  sc_note_scorer dut (
    .clk           (clk),
    .reset         (reset),
    .song_time     (song_time),
    .match_trigger (match_trigger),
    .match_time    (match_time),
    .grade_valid   (grade_valid),
    .grade         (grade),
    .grade_note    (grade_note),
    .score         (score),
    .combo         (combo),
    .max_combo     (max_combo),
    .multiplier    (multiplier),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int note;
    int grade;
    int score;
    int combo;
    int max_combo;
    int mult;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  int m_score = 0;
  int m_combo = 0;
  int m_max   = 0;
  int m_mult  = 1;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_score = 0; m_combo = 0; m_max = 0; m_mult = 1;
  endtask

  // Grade a hit with the given error and push the expected outputs.
  task automatic push_hit(input int lane, input int err);
    exp_t e;
    int g, pts;
    if (err <= 8)       begin g = 3; pts = 100; end
    else if (err <= 20) begin g = 2; pts = 50;  end
    else if (err <= 40) begin g = 1; pts = 20;  end
    else                begin g = 0; pts = 0;   end
    m_score = m_score + pts * m_mult;
    if (m_score > 24'hFFFFFF) m_score = 24'hFFFFFF;
    if (g == 0) m_combo = 0;
    else if (m_combo < 4095) m_combo = m_combo + 1;
    if (m_combo > m_max) m_max = m_combo;
    m_mult = 1 + m_combo / 10;
    if (m_mult > 4) m_mult = 4;
    e.note = lane; e.grade = g; e.score = m_score;
    e.combo = m_combo; e.max_combo = m_max; e.mult = m_mult;
    sb.push_back(e);
  endtask

  function automatic int err_of(input int mt);
    int d;
    d = int'(song_time) - mt;
    if (d < 0) d = -d;
    if (d > 255) d = 255;
    return d;
  endfunction

  task automatic set_mt(input int lane, input int mt);
    match_time[TW*lane +: TW] = TW'(mt);
  endtask

  // Present a trigger mask for exactly one capture edge.
  task automatic drive(input logic [NN-1:0] mask);
    @(negedge clk);
    match_trigger = mask;
    @(posedge clk);
    #1;
    match_trigger = '0;
  endtask

  task automatic fire_one(input int lane, input int mt);
    logic [NN-1:0] m;
    set_mt(lane, mt);
    push_hit(lane, err_of(mt));
    m = '0;
    m[lane] = 1'b1;
    drive(m);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gv"},    grade_valid, 0);
    check({tag, "_grade"}, grade, 0);
    check({tag, "_note"},  grade_note, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_combo"}, combo, 0);
    check({tag, "_max"},   max_combo, 0);
    check({tag, "_mult"},  multiplier, 1);
    check({tag, "_drop"},  drop_count, 0);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (grade_valid) begin
      if (sb.size() == 0) begin
        check("spurious_gv", grade_valid, 0);
      end else begin
        e = sb.pop_front();
        check("grade_note", grade_note, e.note);
        check("grade",      grade,      e.grade);
        check("score",      score,      e.score);
        check("combo",      combo,      e.combo);
        check("max_combo",  max_combo,  e.max_combo);
        check("multiplier", multiplier, e.mult);
      end
    end
  end

  initial begin
    int errs[6];
    int pulses;
    logic [NN-1:0] m;
    errs = '{8, 9, 20, 21, 40, 41};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Single hit with latency check
    song_time = TW'(1000);
    fire_one(5, 1003);
    @(posedge clk); #1;
    check("lat_edge2_gv", grade_valid, 0);
    @(posedge clk); #1;
    check("lat_edge3_gv", grade_valid, 1);
    check("single_score", score, 100);
    check("single_mult", multiplier, 1);
    idle(4);

    // Window edges, both sides of song_time
    for (int k = 0; k < 6; k++) begin
      fire_one(10, (k % 2) ? 1000 + errs[k] : 1000 - errs[k]);
      idle(4);
    end
    check("combo_after_miss", combo, 0);
    check("max_combo_windows", max_combo, 6);

    // Large difference saturates into a MISS
    song_time = TW'(200000);
    fire_one(2, 10);
    idle(5);
    check("sat_miss_grade", grade, 0);
    song_time = TW'(1000);

    // Multiplier progression
    do_reset();
    for (int k = 0; k < 10; k++) fire_one(k, 1000);
    idle(5);
    check("mult10_score", score, 1000);
    check("mult10_combo", combo, 10);
    check("mult10_mult", multiplier, 2);
    fire_one(10, 1000);
    idle(5);
    check("mult11_score", score, 1200);
    check("mult11_mult", multiplier, 2);
    for (int k = 11; k < 35; k++) fire_one(k, 1002);
    idle(5);
    check("mult35_combo", combo, 35);
    check("mult35_mult", multiplier, 4);

    // 37-lane burst from ptr=0 drains in consecutive cycles
    do_reset();
    for (int i = 0; i < NN; i++) begin
      set_mt(i, 1000 + (i * 7) % 50);
      push_hit(i, (i * 7) % 50);
    end
    drive('1);
    @(posedge clk); #1;
    for (int i = 0; i < NN; i++) begin
      @(posedge clk); #1;
      check("burst_gv", grade_valid, 1);
      check("burst_note", grade_note, i);
    end
    idle(3);
    // ptr must be back at 0: lane 0 wins over lane 36
    set_mt(0, 1000);
    set_mt(36, 1010);
    push_hit(0, 0);
    push_hit(36, 10);
    m = '0; m[0] = 1'b1; m[36] = 1'b1;
    drive(m);
    idle(5);

    // Drop / overlap while all lanes pending
    for (int i = 0; i < NN; i++) begin
      set_mt(i, 1000 + (i * 7) % 50);
      push_hit(i, (i * 7) % 50);
    end
    drive('1);
    repeat (3) @(posedge clk);
    set_mt(20, 1000);
    m = '0; m[20] = 1'b1;
    drive(m);                                // lane 3 granted: lane 20 dropped
    #1;
    check("drop_one", drop_count, 1);
    repeat (3) @(posedge clk);
    set_mt(7, 1003);
    push_hit(7, 3);
    m = '0; m[7] = 1'b1;
    drive(m);                                // lane 7 granted: recaptured
    #1;
    check("no_drop_on_grant", drop_count, 1);
    repeat (2) @(posedge clk);
    m = '0;
    for (int i = 30; i < 35; i++) m[i] = 1'b1;
    drive(m);                                // lane 10 granted: five drops
    #1;
    check("multi_drop", drop_count, 6);
    idle(50);
    check("sb_empty_drop", sb.size(), 0);

    // Reset during a drain
    do_reset();
    for (int i = 0; i < NN; i++) begin
      set_mt(i, 1000);
      push_hit(i, 0);
    end
    drive('1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (grade_valid) pulses++;
    end
    check("pulses_after_reset", pulses, 0);
    check("score_after_reset", score, 0);

    check("sb_empty_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
